sliding_window_buffer: RTL and testbench
========================================

SLIDING_WINDOW_BUFFER -- requirements
Module: sliding_window_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, sample width in bits.
REQ-002 SHALL have parameter WINDOW_SIZE, default 64, window depth in samples; power of two, minimum 2.
REQ-003 SHALL have derived localparam ADDR_WIDTH = $clog2(WINDOW_SIZE).
REQ-004 SHALL have one clock and a synchronous, active-high reset: i_clk input 1 (rising-edge clock); i_reset input 1 (synchronous active-high reset).
REQ-005 SHALL have the following ports:
- i_data_valid  input  1  upstream sample valid
- i_data  input  DATA_WIDTH  new sample
- o_ready  output  1  sample accepted when high with i_data_valid
- o_data_valid  output  1  output pair valid
- i_ready  input  1  downstream (moving_stats) ready
- o_incoming_data  output  DATA_WIDTH  sample entering the window
- o_outgoing_data  output  DATA_WIDTH  sample leaving the window
- o_window_full  output  1  window holds WINDOW_SIZE samples
- o_count  output  ADDR_WIDTH+1  samples currently in window

Function
REQ-006 SHALL store samples in a circular buffer addressed by a write pointer wr_ptr of ADDR_WIDTH bits.
REQ-007 SHALL accept a sample on a cycle where i_data_valid && o_ready.
REQ-008 SHALL drive o_ready = !o_data_valid || i_ready, as a single-entry output register with no bubble under continuous flow.
REQ-009 SHALL, on accept, read the old entry at wr_ptr, write i_data to wr_ptr, and increment wr_ptr modulo WINDOW_SIZE, all in the same cycle (read-before-write).
REQ-010 SHALL present o_incoming_data = accepted sample and o_data_valid = 1 exactly one cycle after accept.
REQ-011 SHALL present o_outgoing_data = evicted sample when o_count == WINDOW_SIZE at accept time, else 0, so a downstream running sum stays exact during fill.
REQ-012 SHALL increment o_count on accept while below WINDOW_SIZE and saturate at WINDOW_SIZE; o_window_full = (o_count == WINDOW_SIZE).
REQ-013 SHALL hold o_incoming_data, o_outgoing_data and o_data_valid stable while o_data_valid && !i_ready.
REQ-014 SHALL clear o_data_valid on a cycle with i_ready high and no accept.
REQ-015 SHALL wrap wr_ptr from WINDOW_SIZE-1 to 0 with no dropped or duplicated sample.
REQ-016 SHALL produce correct evicted data regardless of RAM contents before first fill; uninitialised RAM is never observable.
REQ-017 SHALL treat all data as opaque bits; no arithmetic on samples.

Reset
REQ-018 SHALL, on i_reset, synchronously clear wr_ptr, o_count, o_window_full, o_data_valid, o_incoming_data and o_outgoing_data to 0; RAM contents not cleared.
REQ-019 SHALL drop any in-flight output pair and deassert o_data_valid when reset occurs mid-stream; the first sample after reset sees o_outgoing_data = 0.
REQ-020 SHALL keep o_ready = 1 during and after reset (o_data_valid = 0).

Configuration
REQ-021 SHALL, with macro SLIDING_WINDOW_FLUSH_EN defined, add input port i_flush (1 bit) that synchronously clears wr_ptr, o_count and o_data_valid as reset does, leaving other outputs unchanged.
REQ-022 SHALL force o_ready = 0 while i_flush is high; flush wins over a simultaneous sample, which is not accepted.
REQ-023 SHALL omit the i_flush port and all flush logic when SLIDING_WINDOW_FLUSH_EN is undefined.

Structure
REQ-024 SHALL take DATA_WIDTH, WINDOW_SIZE defaults and typedef data_t (logic [DATA_WIDTH-1:0]) from shared package hft_pkg, also used by moving_stats.
REQ-025 SHALL instantiate one sub-module window_ram: simple dual-port, synchronous read, read-during-write returning old data.

Verification
REQ-026 SHALL cover fill: WINDOW_SIZE=4, reset, send 1,2,3,4 back-to-back -> outgoing 0,0,0,0; incoming 1..4; o_count 1..4; o_window_full high after the 4th.
REQ-027 SHALL cover eviction/wrap: continue with 5,6,7,8,9 -> outgoing 1,2,3,4,5; o_count stays 4.
REQ-028 SHALL cover backpressure: i_ready low 3 cycles with o_data_valid high -> o_ready low, outputs stable, no sample lost; stream resumes in order.
REQ-029 SHALL cover reset mid-stream: reset after 6 samples, send 10 -> o_outgoing_data 0, o_count 1.
REQ-030 SHALL cover flush (SLIDING_WINDOW_FLUSH_EN): i_flush and i_data_valid (value 42) in the same cycle -> 42 not accepted, o_count 0; next sample 7 -> outgoing 0, o_count 1.
REQ-031 SHALL cover continuous flow: 100 random samples with i_ready=1 -> one output per cycle; outgoing equals the input from 4 accepts earlier, checked against a scoreboard.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared constants and sample type for the HFT datapath (sliding_window_buffer, moving_stats).
package hft_pkg;

    localparam int unsigned HFT_DATA_WIDTH  = 32;
    localparam int unsigned HFT_WINDOW_SIZE = 64;

    typedef logic [HFT_DATA_WIDTH-1:0] data_t;

endpackage : hft_pkg

// File: rtl/window_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old contents.
module window_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Non-blocking update gives read-before-write on an address collision.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : window_ram

// File: rtl/sliding_window_buffer.sv
// Circular window of the last WINDOW_SIZE samples; emits (incoming, evicted) pairs for a running sum.
// Optional flush input enabled by defining SLIDING_WINDOW_FLUSH_EN.
module sliding_window_buffer
    import hft_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = HFT_DATA_WIDTH,
    parameter  int unsigned WINDOW_SIZE = HFT_WINDOW_SIZE,
    localparam int unsigned ADDR_WIDTH  = $clog2(WINDOW_SIZE)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_data_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_data_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_incoming_data,
    output logic [DATA_WIDTH-1:0] o_outgoing_data,
    output logic                  o_window_full,
    output logic [ADDR_WIDTH:0]   o_count
`ifdef SLIDING_WINDOW_FLUSH_EN
    ,
    input  logic                  i_flush
`endif
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(WINDOW_SIZE);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] incoming_q, incoming_d;
    logic                  evict_q, evict_d;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  accept;

    // Single-entry output stage: ready whenever the held pair is empty or being consumed.
`ifdef SLIDING_WINDOW_FLUSH_EN
    assign o_ready = !i_flush && (i_reset || !valid_q || i_ready);
`else
    assign o_ready = i_reset || !valid_q || i_ready;
`endif

    assign accept = i_data_valid && o_ready && !i_reset;

    window_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_window_ram (
        .clk_i  (i_clk),
        .we_i   (accept),
        .waddr_i(wr_ptr_q),
        .wdata_i(i_data),
        .re_i   (accept),
        .raddr_i(wr_ptr_q),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        full_d     = full_q;
        valid_d    = valid_q;
        incoming_d = incoming_q;
        evict_d    = evict_q;

        if (accept) begin
            wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(1);
            if (!full_q) begin
                count_d = count_q + CNT_W'(1);
            end
            valid_d    = 1'b1;
            incoming_d = i_data;
            // Only a full window evicts; during fill the outgoing value is forced to zero.
            evict_d    = full_q;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end

`ifdef SLIDING_WINDOW_FLUSH_EN
        if (i_flush) begin
            wr_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end
`endif

        full_d = (count_d == FULL_COUNT);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            valid_q    <= 1'b0;
            incoming_q <= '0;
            evict_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            valid_q    <= valid_d;
            incoming_q <= incoming_d;
            evict_q    <= evict_d;
        end
    end

    // RAM read data is held between accepts, so this stays stable under backpressure.
    assign o_outgoing_data = evict_q ? ram_rdata : '0;
    assign o_incoming_data = incoming_q;
    assign o_data_valid    = valid_q;
    assign o_window_full   = full_q;
    assign o_count         = count_q;

endmodule : sliding_window_buffer

// File: tb/tb_sliding_window_buffer.sv
// Directed + random bench for sliding_window_buffer (WINDOW_SIZE=4) against a queue-based window model.
module tb_sliding_window_buffer;
    import hft_pkg::*;

    localparam int unsigned WS = 4;
    localparam int unsigned AW = $clog2(WS);

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_data_valid;
    data_t         i_data;
    logic          o_ready;
    logic          o_data_valid;
    logic          i_ready;
    data_t         o_incoming_data;
    data_t         o_outgoing_data;
    logic          o_window_full;
    logic [AW:0]   o_count;
`ifdef SLIDING_WINDOW_FLUSH_EN
    logic          i_flush;
`endif

    int    errors = 0;
    int    checks = 0;
    data_t win_q[$];
    data_t last_in;
    data_t last_out;

    always #5 clk = ~clk;

    sliding_window_buffer #(
        .DATA_WIDTH (HFT_DATA_WIDTH),
        .WINDOW_SIZE(WS)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_data_valid   (i_data_valid),
        .i_data         (i_data),
        .o_ready        (o_ready),
        .o_data_valid   (o_data_valid),
        .i_ready        (i_ready),
        .o_incoming_data(o_incoming_data),
        .o_outgoing_data(o_outgoing_data),
        .o_window_full  (o_window_full),
        .o_count        (o_count)
`ifdef SLIDING_WINDOW_FLUSH_EN
        ,
        .i_flush        (i_flush)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pair(input string tag);
        chk({tag, ".valid"},    32'(o_data_valid),     32'(1));
        chk({tag, ".incoming"}, 32'(o_incoming_data),  32'(last_in));
        chk({tag, ".outgoing"}, 32'(o_outgoing_data),  32'(last_out));
        chk({tag, ".count"},    32'(o_count),          32'(win_q.size()));
        chk({tag, ".full"},     32'(o_window_full),    32'(win_q.size() == WS));
    endtask

    // Called at a negedge; ends at the following negedge with the new pair checked.
    task automatic accept_step(input string tag, input data_t val);
        i_data_valid = 1'b1;
        i_data       = val;
        i_ready      = 1'b1;
        #1;
        chk({tag, ".ready"}, 32'(o_ready), 32'(1));
        if (win_q.size() == WS) last_out = win_q.pop_front();
        else                    last_out = '0;
        win_q.push_back(val);
        last_in = val;
        @(posedge clk);
        @(negedge clk);
        check_pair(tag);
    endtask

    task automatic hold_step(input string tag, input data_t val);
        i_data_valid = 1'b1;
        i_data       = val;
        i_ready      = 1'b0;
        #1;
        chk({tag, ".ready"}, 32'(o_ready), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check_pair(tag);
    endtask

    task automatic idle_step(input string tag);
        i_data_valid = 1'b0;
        i_ready      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(o_data_valid), 32'(0));
        chk({tag, ".count"}, 32'(o_count),      32'(win_q.size()));
    endtask

    task automatic reset_step(input string tag);
        i_reset      = 1'b1;
        i_data_valid = 1'b0;
        i_ready      = 1'b0;
        #1;
        chk({tag, ".ready_in_reset"}, 32'(o_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        i_ready = 1'b1;
        win_q.delete();
        #1;
        chk({tag, ".valid"},    32'(o_data_valid),    32'(0));
        chk({tag, ".count"},    32'(o_count),         32'(0));
        chk({tag, ".full"},     32'(o_window_full),   32'(0));
        chk({tag, ".incoming"}, 32'(o_incoming_data), 32'(0));
        chk({tag, ".outgoing"}, 32'(o_outgoing_data), 32'(0));
        chk({tag, ".ready"},    32'(o_ready),         32'(1));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset      = 1'b1;
        i_data_valid = 1'b0;
        i_data       = '0;
        i_ready      = 1'b1;
`ifdef SLIDING_WINDOW_FLUSH_EN
        i_flush      = 1'b0;
`endif
        @(negedge clk);
        reset_step("reset0");

        for (int v = 1; v <= 4; v++) accept_step("fill", data_t'(v));
        for (int v = 5; v <= 9; v++) accept_step("wrap", data_t'(v));

        for (int k = 0; k < 3; k++) hold_step("bp_hold", data_t'(10));
        accept_step("bp_resume", data_t'(10));
        accept_step("bp_next", data_t'(11));
        idle_step("drain");

        reset_step("reset1");
        for (int v = 20; v < 26; v++) accept_step("pre_reset", data_t'(v));
        reset_step("reset_mid");
        accept_step("post_reset", data_t'(10));

`ifdef SLIDING_WINDOW_FLUSH_EN
        accept_step("pre_flush", data_t'(3));
        i_flush      = 1'b1;
        i_data_valid = 1'b1;
        i_data       = data_t'(42);
        i_ready      = 1'b1;
        #1;
        chk("flush.ready", 32'(o_ready), 32'(0));
        @(posedge clk);
        @(negedge clk);
        i_flush      = 1'b0;
        i_data_valid = 1'b0;
        win_q.delete();
        #1;
        chk("flush.valid", 32'(o_data_valid),  32'(0));
        chk("flush.count", 32'(o_count),       32'(0));
        chk("flush.full",  32'(o_window_full), 32'(0));
        @(negedge clk);
        accept_step("post_flush", data_t'(7));
`endif

        for (int n = 0; n < 100; n++) accept_step("stream", data_t'($urandom()));
        idle_step("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sliding_window_buffer
